// File: rtl/udc_pkg.sv
// rtl/udc_pkg.sv - opcodes, decade limit and FSM state encoding shared by udc_seq and udc_core
package udc_pkg;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [3:0] DEC_MAX = 4'd9;
  localparam logic [3:0] BIN_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/udc_core.sv
// rtl/udc_core.sv - 4-bit binary/decade up/down counter with sync load and registered wrap flag
module udc_core
  import udc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       dir,
  input  logic       mode,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] q,
  output logic       wrap
);

  logic [3:0] q_next;
  logic       wrap_next;

  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (load) begin
      q_next = (mode && load_val > DEC_MAX) ? DEC_MAX : load_val;
    end else if (en) begin
      if (!dir) begin
        if (q == BIN_MAX || (mode && q >= DEC_MAX)) begin
          q_next    = 4'd0;
          wrap_next = 1'b1;
        end else begin
          q_next = q + 4'd1;
        end
      end else begin
        if (q == 4'd0) begin
          q_next    = mode ? DEC_MAX : BIN_MAX;
          wrap_next = 1'b1;
        end else if (mode && q > DEC_MAX) begin
          // out-of-range decade value snaps back into range; not a wrap
          q_next = DEC_MAX;
        end else begin
          q_next = q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q    <= 4'd0;
      wrap <= 1'b0;
    end else begin
      q    <= q_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: rtl/udc_seq.sv
// rtl/udc_seq.sv - command sequencer: accepts LOAD/UP/DOWN/CLEAR and steps udc_core one count per cycle
module udc_seq
  import udc_pkg::*;
#(
  parameter int ARG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  input  logic             mode,
  input  logic             abort,
  output logic [3:0]       q,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             wrap
);

  state_t           state;
  state_t           state_next;
  logic [ARG_W-1:0] remaining;
  logic             dir_q;
  logic             mode_q;
  logic             accept;
  logic             core_en;
  logic             core_load;
  logic             core_mode;
  logic [3:0]       load_val;
  logic             is_step_op;

  assign is_step_op = (cmd_op == OP_UP) || (cmd_op == OP_DOWN);
  // LOAD samples the live mode input; runs use the mode latched at accept
  assign core_mode  = (state == ST_IDLE) ? mode : mode_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    core_en    = 1'b0;
    core_load  = 1'b0;
    load_val   = 4'(cmd_arg);
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        accept    = cmd_valid;
        if (cmd_valid) begin
          if (!is_step_op) begin
            core_load  = 1'b1;
            if (cmd_op == OP_CLEAR) load_val = 4'd0;
            state_next = ST_DONE;
          end else if (cmd_arg == '0) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        // abort wins over the final step
        if (abort) begin
          state_next = ST_DONE;
        end else begin
          core_en = 1'b1;
          if (remaining == ARG_W'(1)) state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= '0;
      dir_q     <= 1'b0;
      mode_q    <= 1'b0;
      aborted   <= 1'b0;
    end else if (accept) begin
      remaining <= is_step_op ? cmd_arg : '0;
      dir_q     <= (cmd_op == OP_DOWN);
      mode_q    <= mode;
      aborted   <= 1'b0;
    end else if (state == ST_RUN) begin
      if (abort) begin
        remaining <= '0;
        aborted   <= 1'b1;
      end else begin
        remaining <= remaining - ARG_W'(1);
      end
    end
  end

  udc_core u_core (
    .clk      (clk),
    .rst      (rst),
    .en       (core_en),
    .dir      (dir_q),
    .mode     (core_mode),
    .load     (core_load),
    .load_val (load_val),
    .q        (q),
    .wrap     (wrap)
  );

endmodule

// File: tb/tb_udc_seq.sv
// tb/tb_udc_seq.sv - randomized bench for udc_seq against a transaction-level expected-trace model
module tb_udc_seq;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef struct packed {
    logic [3:0] q;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       wrap;
    logic       ready;
    logic       abort_in;
    logic       in_run;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_arg;
  logic       mode;
  logic       abort;
  logic [3:0] q;
  logic       busy;
  logic       done;
  logic       aborted;
  logic       wrap;

  udc_seq #(.ARG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .mode      (mode),
    .abort     (abort),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .aborted   (aborted),
    .wrap      (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   wrap_seen = 0;
  bit   chk_en = 0;
  rec_t exp_r;
  rec_t exp_q[$];
  logic [3:0] mq = 4'd0;
  logic       m_aborted = 1'b0;

  bit         pend_valid = 0;
  bit         pend_early = 0;
  logic [1:0] pend_op;
  logic [3:0] pend_arg;
  logic       pend_md;
  int         pend_abort;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d at t=%0t", name, got, want, $time);
    end
  endtask

  function automatic rec_t mk(input logic [3:0] qv, input logic b, input logic d, input logic ab,
                              input logic w, input logic rd, input logic ain, input logic run);
    rec_t r;
    r.q = qv; r.busy = b; r.done = d; r.aborted = ab;
    r.wrap = w; r.ready = rd; r.abort_in = ain; r.in_run = run;
    return r;
  endfunction

  // one count step from the counting rules: returns {wrapped, new value}
  function automatic logic [4:0] nxt(input logic [3:0] qv, input logic dn, input logic md);
    int lim;
    lim = md ? 9 : 15;
    if (!dn) return (int'(qv) >= lim) ? 5'b1_0000 : {1'b0, qv + 4'd1};
    if (qv == 4'd0) return {1'b1, 4'(lim)};
    if (md && qv > 4'd9) return {1'b0, 4'd9};
    return {1'b0, qv - 4'd1};
  endfunction

  // expected output trace for every cycle after the accept edge, through the done cycle
  task automatic build(input logic [1:0] op, input logic [3:0] arg, input logic md, input int ab);
    logic       w;
    logic       dn;
    logic [4:0] s;
    bit         stop;
    m_aborted = 1'b0;
    dn = (op == OP_DOWN);
    if (op == OP_LOAD || op == OP_CLEAR || arg == 4'd0) begin
      if (op == OP_LOAD) mq = (md && arg > 4'd9) ? 4'd9 : arg;
      else if (op == OP_CLEAR) mq = 4'd0;
      exp_q.push_back(mk(mq, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    end else begin
      w = 1'b0;
      stop = 0;
      for (int j = 0; j < int'(arg) && !stop; j++) begin
        exp_q.push_back(mk(mq, 1'b1, 1'b0, 1'b0, w, 1'b0, (j == ab), 1'b1));
        if (j == ab) begin
          exp_q.push_back(mk(mq, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
          m_aborted = 1'b1;
          stop = 1;
        end else begin
          s = nxt(mq, dn, md);
          w = s[4];
          mq = s[3:0];
          if (j == int'(arg) - 1)
            exp_q.push_back(mk(mq, 1'b1, 1'b1, 1'b0, w, 1'b0, 1'b0, 1'b0));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("q", 32'(q), 32'(exp_r.q));
      check("busy", 32'(busy), 32'(exp_r.busy));
      check("done", 32'(done), 32'(exp_r.done));
      check("aborted", 32'(aborted), 32'(exp_r.aborted));
      check("wrap", 32'(wrap), 32'(exp_r.wrap));
      check("cmd_ready", 32'(cmd_ready), 32'(exp_r.ready));
      if (wrap === 1'b1) wrap_seen++;
    end
  end

  task automatic cycle();
    bit idle;
    @(posedge clk);
    #1;
    idle = (exp_q.size() == 0);
    if (idle) exp_r = mk(mq, 1'b0, 1'b0, m_aborted, 1'b0, 1'b1, 1'b0, 1'b0);
    else exp_r = exp_q.pop_front();
    chk_en = 1;
    if (exp_r.in_run) abort = exp_r.abort_in;
    else abort = 1'($urandom_range(0, 1));
    if (pend_valid && (idle || pend_early)) begin
      cmd_valid = 1'b1;
      cmd_op = pend_op;
      cmd_arg = pend_arg;
      mode = pend_md;
    end else begin
      cmd_valid = 1'b0;
      cmd_op = 2'($urandom);
      cmd_arg = 4'($urandom);
      mode = 1'($urandom);
    end
    if (idle && pend_valid) begin
      build(pend_op, pend_arg, pend_md, pend_abort);
      pend_valid = 0;
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] arg, input logic md,
                       input int ab, input bit early);
    int n;
    n = 0;
    pend_op = op; pend_arg = arg; pend_md = md; pend_abort = ab; pend_early = early;
    pend_valid = 1;
    while (pend_valid && n < 100) begin
      cycle();
      n++;
    end
    check("accept_timeout", 32'(pend_valid), 32'd0);
    pend_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      cycle();
      n++;
    end
    check("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cycle();
  endtask

  task automatic reset_mid(input int steps);
    issue(OP_UP, 4'd8, 1'b0, -1, 0);
    repeat (steps) cycle();
    @(posedge clk);
    #3;
    chk_en = 0;
    rst = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    #1;
    check("rst_mid_q", 32'(q), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    check("rst_mid_wrap", 32'(wrap), 32'd0);
    exp_q.delete();
    mq = 4'd0;
    m_aborted = 1'b0;
    @(posedge clk);
    #3;
    check("rst_hold_done", 32'(done), 32'd0);
    rst = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish before t=500000");
    $fatal(1);
  end

  initial begin
    logic [1:0] op;
    logic [3:0] arg;
    logic       md;
    int         ab;
    rst = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 4'd0; mode = 1'b0; abort = 1'b0;
    #12;
    check("reset_q", 32'(q), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_aborted", 32'(aborted), 32'd0);
    check("reset_wrap", 32'(wrap), 32'd0);
    @(posedge clk);
    #3;
    rst = 1'b1;

    issue(OP_UP, 4'd3, 1'b0, -1, 0); drain();
    check("up3_q", 32'(q), 32'd3);
    check("up3_ready", 32'(cmd_ready), 32'd1);

    issue(OP_LOAD, 4'd14, 1'b0, -1, 0); drain();
    check("load14_q", 32'(q), 32'd14);
    wrap_seen = 0;
    issue(OP_UP, 4'd3, 1'b0, -1, 0); drain();
    check("bin_wrap_q", 32'(q), 32'd1);
    check("bin_wrap_count", 32'(wrap_seen), 32'd1);
    check("bin_wrap_aborted", 32'(aborted), 32'd0);

    issue(OP_LOAD, 4'd12, 1'b1, -1, 0); drain();
    check("dec_clamp_q", 32'(q), 32'd9);
    wrap_seen = 0;
    issue(OP_UP, 4'd1, 1'b1, -1, 0); drain();
    check("dec_up_q", 32'(q), 32'd0);
    check("dec_up_wrap", 32'(wrap_seen), 32'd1);
    wrap_seen = 0;
    issue(OP_DOWN, 4'd2, 1'b1, -1, 0); drain();
    check("dec_down_q", 32'(q), 32'd8);
    check("dec_down_wrap", 32'(wrap_seen), 32'd1);

    issue(OP_CLEAR, 4'd7, 1'b0, -1, 0); drain();
    issue(OP_UP, 4'd10, 1'b0, 4, 0); drain();
    check("abort_q", 32'(q), 32'd4);
    check("abort_flag", 32'(aborted), 32'd1);
    issue(OP_LOAD, 4'd5, 1'b0, -1, 0); drain();
    check("after_abort_q", 32'(q), 32'd5);
    check("after_abort_flag", 32'(aborted), 32'd0);

    reset_mid(3);
    wrap_seen = 0;
    issue(OP_DOWN, 4'd1, 1'b0, -1, 0); drain();
    check("post_rst_down_q", 32'(q), 32'd15);
    check("post_rst_down_wrap", 32'(wrap_seen), 32'd1);

    issue(OP_LOAD, 4'd3, 1'b0, -1, 0); drain();
    issue(OP_UP, 4'd5, 1'b0, -1, 0);
    issue(OP_DOWN, 4'd2, 1'b1, -1, 1); drain();
    check("held_cmd_q", 32'(q), 32'd6);
    issue(OP_UP, 4'd0, 1'b0, -1, 0); drain();
    check("up0_q", 32'(q), 32'd6);

    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom);
      arg = 4'($urandom);
      md = 1'($urandom);
      ab = -1;
      if (arg != 4'd0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(0, int'(arg) - 1));
      issue(op, arg, md, ab, bit'($urandom_range(0, 1)));
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
